// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Memory-side responder for the CPU control sequencer's memory handshake.
//   It latches the address the sequencer presents and holds a word-addressed
//   synchronous RAM. Read data comes back during the second data_in cycle of
//   a read. Write data is committed on the data_out cycle of a store.
//   Handshake violations set a sticky error flag.
//
// Ports
//   clk          : single clock, all state updates on posedge
//   rst          : synchronous active-high reset (RAM contents preserved)
//   address_read : latch addr_bus into addr_q this cycle
//   addr_bus     : address from PC / mp16 / ALU-mem unit
//   data_in      : CPU read strobe (qualified by mem_enable)
//   data_out     : CPU write strobe (qualified by mem_enable)
//   mem_enable   : memory cycle strobe
//   wdata        : store data from the accumulator
//   rdata        : registered read data, holds its value when not valid
//   rdata_valid  : rdata drives the data bus this cycle
//   addr_q       : currently latched address
//   proto_error  : sticky handshake-violation flag
module mem_bus_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  address_read,
  input  logic [ADDR_WIDTH-1:0] addr_bus,
  input  logic                  data_in,
  input  logic                  data_out,
  input  logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic [ADDR_WIDTH-1:0] addr_q,
  output logic                  proto_error
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ARMED,
    S_READ
  } state_t;

  state_t state, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             rd, wr, both;
  logic             do_rd, do_wr, err_set;
  logic [IDX_W-1:0] idx;

  assign rd   = data_in  & mem_enable & ~data_out;
  assign wr   = data_out & mem_enable & ~data_in;
  assign both = data_in  & data_out   & mem_enable;

  // Upper address bits are dropped so memory mirrors across the address space.
  assign idx = addr_q[IDX_W-1:0];

  // Decoded from the registered state only; no path from inputs.
  assign rdata_valid = (state == S_READ);

  always_comb begin
    state_d = state;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    err_set = 1'b0;
    if (address_read) begin
      // Address latch wins; any memory strobe alongside it is a violation.
      state_d = S_ARMED;
      err_set = rd | wr | both;
    end else begin
      unique case (state)
        S_EMPTY: begin
          err_set = rd | wr | both;
        end
        S_ARMED: begin
          if (rd) begin
            do_rd   = 1'b1;
            state_d = S_READ;
          end else if (wr) begin
            do_wr = 1'b1;
          end else if (both) begin
            err_set = 1'b1;
          end
        end
        S_READ: begin
          // Second read cycle (or anything else) returns to ARMED.
          state_d = S_ARMED;
          err_set = wr | both;
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_EMPTY;
      addr_q      <= '0;
      rdata       <= '0;
      proto_error <= 1'b0;
    end else begin
      state <= state_d;
      if (address_read) begin
        addr_q <= addr_bus;
      end
      if (do_rd) begin
        rdata <= mem[idx];
      end
      if (err_set) begin
        proto_error <= 1'b1;
      end
    end
  end

  // RAM has no reset; rst only blocks a write in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          address_read = 1'b0;
  logic [AW-1:0] addr_bus = '0;
  logic          data_in = 1'b0;
  logic          data_out = 1'b0;
  logic          mem_enable = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic [AW-1:0] addr_q;
  logic          proto_error;

  mem_bus_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address_read(address_read),
    .addr_bus(addr_bus),
    .data_in(data_in),
    .data_out(data_out),
    .mem_enable(mem_enable),
    .wdata(wdata),
    .rdata(rdata),
    .rdata_valid(rdata_valid),
    .addr_q(addr_q),
    .proto_error(proto_error)
  );

  always #5 clk = ~clk;

  // Expected visible outputs after one clock edge.
  typedef struct {
    bit          valid;
    logic [DW-1:0] rdata;
    bit          rchk;
    logic [AW-1:0] addr;
    bit          err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the memory-side agent must have observed so far.
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_have_addr;   // an address was latched since reset
  bit            m_reading;     // first read cycle done, data on the bus
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata;
  bit            m_rdata_known;
  bit            m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rdata_valid", 32'(rdata_valid), 32'(mon_e.valid));
      chk("addr_q", 32'(addr_q), 32'(mon_e.addr));
      chk("proto_error", 32'(proto_error), 32'(mon_e.err));
      if (mon_e.rchk) chk("rdata", 32'(rdata), 32'(mon_e.rdata));
    end
  end

  // One clock cycle of stimulus; the model computes the outcome and queues it.
  task automatic step(input bit r, input bit ar, input logic [AW-1:0] a,
                      input bit di, input bit dd, input bit me, input logic [DW-1:0] w);
    bit   rdq, wrq, bothq, any;
    int   ix;
    exp_t e;
    @(negedge clk);
    rst = r; address_read = ar; addr_bus = a;
    data_in = di; data_out = dd; mem_enable = me; wdata = w;
    rdq   = di & me & ~dd;
    wrq   = dd & me & ~di;
    bothq = di & dd & me;
    any   = rdq | wrq | bothq;
    if (r) begin
      m_have_addr = 0; m_reading = 0; m_addr = '0; m_err = 0;
      m_rdata = '0; m_rdata_known = 1;
    end else if (ar) begin
      if (any) m_err = 1;
      m_addr = a; m_have_addr = 1; m_reading = 0;
    end else if (!m_have_addr) begin
      if (any) m_err = 1;
    end else if (m_reading) begin
      m_reading = 0;
      if (wrq | bothq) m_err = 1;
    end else begin
      ix = int'(m_addr) % DEPTH;
      if (rdq) begin
        m_rdata = m_mem[ix]; m_rdata_known = m_known[ix]; m_reading = 1;
      end else if (wrq) begin
        m_mem[ix] = w; m_known[ix] = 1;
      end else if (bothq) begin
        m_err = 1;
      end
    end
    e.valid = m_reading; e.rdata = m_rdata; e.rchk = m_rdata_known;
    e.addr = m_addr; e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_rst();  step(1, 0, 16'h0, 0, 0, 0, 8'h00); endtask
  task automatic idle();    step(0, 0, 16'h0, 0, 0, 0, 8'h00); endtask
  task automatic arm(input logic [AW-1:0] a); step(0, 1, a, 0, 0, 0, 8'h00); endtask
  task automatic rd();      step(0, 0, 16'h0, 1, 0, 1, 8'h00); endtask
  task automatic wr(input logic [DW-1:0] w); step(0, 0, 16'h0, 0, 1, 1, w); endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] w);
    arm(a); idle(); wr(w);
  endtask

  task automatic load(input logic [AW-1:0] a);
    arm(a); rd(); rd();
  endtask

  initial begin
    bit            r, ar, di, dd, me;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    int            sel;
    for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 0;

    do_rst(); do_rst();

    // Read before any address latched.
    rd(); idle();
    do_rst();

    // Fetch pattern and store/load.
    store(16'h0010, 8'h5A);
    load(16'h0010); idle();
    store(16'h0123, 8'hC3);
    load(16'h0123); idle();

    // Mirroring across the address space.
    store(16'hF005, 8'h7E);
    load(16'h0005); idle();

    // BOTH in ARMED: no write, error raised.
    do_rst();
    arm(16'h0010); step(0, 0, 16'h0, 1, 1, 1, 8'hFF);
    load(16'h0010); idle();

    // address_read together with WR: address taken, no write.
    do_rst();
    step(0, 1, 16'h0123, 0, 1, 1, 8'h99);
    load(16'h0123); idle();

    // Consecutive writes, then read back.
    do_rst();
    arm(16'h0200); wr(8'h11); wr(8'h22);
    load(16'h0200);
    // Address latch directly after a READ cycle.
    arm(16'h0010); rd(); rd(); idle();

    // Reset during the READ cycle.
    arm(16'h0010); rd(); do_rst();
    load(16'h0010); load(16'h0123); idle();

    // Randomized traffic over a few hot indices with random upper bits.
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom % 50) == 0;
      ar = ($urandom % 5) == 0;
      me = ($urandom % 4) != 0;
      sel = int'($urandom % 8);
      di = (sel <= 3) || (sel == 6);
      dd = (sel == 4) || (sel == 5) || (sel == 6);
      a  = AW'($urandom);
      if (($urandom % 4) != 0) a[11:0] = 12'($urandom_range(0, 7));
      w  = DW'($urandom);
      step(r, ar, a, di, dd, me, w);
    end

    idle(); idle();
    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
